spi_target_phy: RTL and testbench

SPI target (slave) physical layer: the responder end of the link that `spiphy` drives as controller. It oversamples the external `sck`, `cs_n` and `mosi` pins in the system clock domain and shifts a holding-register word out on `miso`. It assembles received bits into words and delivers them with a valid pulse. The block sits between the SPI pins and a TileLink register front-end that owns the holding/receive registers.

---
 rtl/spitgt_pkg.sv | 22 ++
 rtl/spi_target_phy_if.sv | 23 ++
 rtl/spi_sync.sv | 33 +++
 rtl/spi_target_phy.sv | 184 ++++++++++++++++++
 tb/tb_spi_target_phy.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spitgt_pkg.sv
// rtl/spitgt_pkg.sv - shared types, constants and helpers for the SPI target PHY
package spitgt_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spitgt_state_e;

    localparam int SPITGT_SYNC_STAGES = 2;
    localparam int SPITGT_MAX_SZ      = 31;

    // Word length minus one, clamped to the 32-bit datapath.
    function automatic logic [4:0] sat_sz(input logic [5:0] sz);
        return (sz > 6'(SPITGT_MAX_SZ)) ? 5'(SPITGT_MAX_SZ) : sz[4:0];
    endfunction

    // Ones in bit positions [sz:0].
    function automatic logic [31:0] sz_mask(input logic [4:0] sz);
        return 32'hFFFF_FFFF >> (5'd31 - sz);
    endfunction

endpackage

// File: rtl/spi_target_phy_if.sv
// rtl/spi_target_phy_if.sv - tx holding-register write and rx word delivery between register front-end and PHY
//   tx_data  : next word to transmit, right-aligned
//   tx_valid : write strobe for the holding register
//   tx_ready : holding register empty
//   rx_data  : last complete received word, right-aligned, upper bits zero
//   rx_valid : one-cycle pulse when rx_data updates
interface spi_target_phy_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop synchronizer for asynchronous pins
//   clk, resetn : system clock, synchronous active-low reset
//   d           : asynchronous inputs
//   q           : inputs after STAGES flops
module spi_sync #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/spi_target_phy.sv
// rtl/spi_target_phy.sv - SPI target physical layer: oversampled pins, tx shift-out, rx word assembly
//   spitgt_clock_i, spitgt_reset_ni : system clock, synchronous active-low reset
//   spitgt_cpol_i, spitgt_cpha_i    : SPI mode, latched at cs_n fall
//   spitgt_sz_i                     : word length minus one (saturates at 31), latched at cs_n fall
//   bus (slave)                     : holding-register write and rx word delivery
//   spitgt_underrun_o               : pulse when a word starts with an empty holding register
//   spitgt_busy_o                   : transfer in progress
//   sck_i, cs_ni, mosi_i            : asynchronous SPI pins
//   miso_o                          : serial data out
//   miso_oe_o                       : present only with SPITGT_MISO_OE_EN; high while ACTIVE
module spi_target_phy
    import spitgt_pkg::*;
(
    input  logic                 spitgt_clock_i,
    input  logic                 spitgt_reset_ni,
    input  logic                 spitgt_cpol_i,
    input  logic                 spitgt_cpha_i,
    input  logic [5:0]           spitgt_sz_i,
    spi_target_phy_if.slave      bus,
    output logic                 spitgt_underrun_o,
    output logic                 spitgt_busy_o,
    input  logic                 sck_i,
    input  logic                 cs_ni,
    input  logic                 mosi_i,
    output logic                 miso_o
`ifdef SPITGT_MISO_OE_EN
    ,
    output logic                 miso_oe_o
`endif
);

    logic sck_s, cs_s, mosi_s;

    // cs_n resets high so a reset never looks like a transfer start.
    spi_sync #(
        .WIDTH     (3),
        .STAGES    (SPITGT_SYNC_STAGES),
        .RESET_VAL (3'b010)
    ) u_sync (
        .clk    (spitgt_clock_i),
        .resetn (spitgt_reset_ni),
        .d      ({sck_i, cs_ni, mosi_i}),
        .q      ({sck_s, cs_s, mosi_s})
    );

    spitgt_state_e state;
    logic        sck_d;
    logic        cpol_q, cpha_q;
    logic [4:0]  sz_q;
    logic [31:0] hold_q;
    logic        hold_full;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic [4:0]  cnt;
    logic        reload_pend;
    logic        miso_q;
    logic [31:0] rx_data_q;
    logic        rx_valid_q;
    logic        underrun_q;

    logic        lead_edge, trail_edge, sample_edge, shift_edge;
    logic        start, active, word_done, reload_cpha0, load_en, wr_en;
    logic [31:0] load_word;
    logic [31:0] tx_shl;
    logic [31:0] rx_next;

    always_comb begin
        lead_edge    = cpol_q ? (sck_d & ~sck_s) : (~sck_d & sck_s);
        trail_edge   = cpol_q ? (~sck_d & sck_s) : (sck_d & ~sck_s);
        sample_edge  = cpha_q ? trail_edge : lead_edge;
        shift_edge   = cpha_q ? lead_edge : trail_edge;

        start        = (state == IDLE) && !cs_s;
        // cs_n rising takes priority over any sck edge in the same cycle.
        active       = (state == ACTIVE) && !cs_s;
        word_done    = active && sample_edge && (cnt == sz_q);
        reload_cpha0 = active && shift_edge && reload_pend;
        load_en      = start || (word_done && cpha_q) || reload_cpha0;

        // Loads see the pre-write holding state; a same-cycle write is for the next word.
        load_word    = hold_full ? hold_q : 32'd0;
        wr_en        = bus.tx_valid && !hold_full;

        tx_shl       = tx_sr << 1;
        rx_next      = {rx_sr[30:0], mosi_s};
    end

    always_ff @(posedge spitgt_clock_i) begin
        if (!spitgt_reset_ni) begin
            state       <= IDLE;
            sck_d       <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            sz_q        <= 5'd0;
            hold_q      <= 32'd0;
            hold_full   <= 1'b0;
            tx_sr       <= 32'd0;
            rx_sr       <= 32'd0;
            cnt         <= 5'd0;
            reload_pend <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= 32'd0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sck_d      <= sck_s;
            rx_valid_q <= 1'b0;
            underrun_q <= load_en && !hold_full;

            if (wr_en) begin
                hold_q    <= bus.tx_data;
                hold_full <= 1'b1;
            end else if (load_en) begin
                hold_full <= 1'b0;
            end

            if (state == IDLE) begin
                if (!cs_s) begin
                    state       <= ACTIVE;
                    cpol_q      <= spitgt_cpol_i;
                    cpha_q      <= spitgt_cpha_i;
                    sz_q        <= sat_sz(spitgt_sz_i);
                    tx_sr       <= load_word;
                    rx_sr       <= 32'd0;
                    cnt         <= 5'd0;
                    reload_pend <= 1'b0;
                    // cpha=0 must present bit sz before the first sampling edge.
                    miso_q      <= spitgt_cpha_i ? 1'b0 : load_word[sat_sz(spitgt_sz_i)];
                end
            end else begin
                if (cs_s) begin
                    state       <= IDLE;
                    cnt         <= 5'd0;
                    miso_q      <= 1'b0;
                    reload_pend <= 1'b0;
                end else begin
                    if (shift_edge) begin
                        if (reload_pend) begin
                            tx_sr       <= load_word;
                            miso_q      <= load_word[sz_q];
                            reload_pend <= 1'b0;
                        end else if (cpha_q) begin
                            miso_q <= tx_sr[sz_q];
                            tx_sr  <= tx_shl;
                        end else begin
                            miso_q <= tx_shl[sz_q];
                            tx_sr  <= tx_shl;
                        end
                    end
                    if (sample_edge) begin
                        if (cnt == sz_q) begin
                            rx_data_q  <= rx_next & sz_mask(sz_q);
                            rx_valid_q <= 1'b1;
                            rx_sr      <= 32'd0;
                            cnt        <= 5'd0;
                            if (cpha_q) begin
                                tx_sr <= load_word;
                            end else begin
                                reload_pend <= 1'b1;
                            end
                        end else begin
                            rx_sr <= rx_next;
                            cnt   <= cnt + 5'd1;
                        end
                    end
                end
            end
        end
    end

    assign bus.tx_ready      = !hold_full;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign spitgt_underrun_o = underrun_q;
    assign spitgt_busy_o     = (state == ACTIVE);

`ifdef SPITGT_MISO_OE_EN
    assign miso_oe_o = (state == ACTIVE);
    assign miso_o    = miso_q & miso_oe_o;
`else
    assign miso_o    = miso_q;
`endif

endmodule

// File: tb/tb_spi_target_phy.sv
// tb/tb_spi_target_phy.sv - self-checking bench for spi_target_phy against a word-level transfer model
module tb_spi_target_phy;

    localparam int H = 5;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0;
    logic [5:0] sz = 6'd7;
    logic       sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic       miso, underrun, busy;
`ifdef SPITGT_MISO_OE_EN
    logic       miso_oe;
`endif

    spi_target_phy_if bus();

    spi_target_phy dut (
        .spitgt_clock_i    (clk),
        .spitgt_reset_ni   (resetn),
        .spitgt_cpol_i     (cpol),
        .spitgt_cpha_i     (cpha),
        .spitgt_sz_i       (sz),
        .bus               (bus),
        .spitgt_underrun_o (underrun),
        .spitgt_busy_o     (busy),
        .sck_i             (sck),
        .cs_ni             (cs_n),
        .mosi_i            (mosi),
        .miso_o            (miso)
`ifdef SPITGT_MISO_OE_EN
        ,
        .miso_oe_o         (miso_oe)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_samp = 0;
    int und_cnt = 0;
    logic [31:0] rx_got [$];
    logic [31:0] exp_rx [$];

    // Holding-register model: one slot, loads take it or yield zero with an underrun.
    logic [31:0] m_hold = 32'd0;
    bit          m_full = 1'b0;
    int          m_und = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.rx_valid) begin
                rx_got.push_back(bus.rx_data);
                check_eq("rx_latency", 32'(cyc - last_samp), 32'd3);
            end
            if (underrun) und_cnt <= und_cnt + 1;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [31:0] v);
        if (!m_full) begin
            m_hold = v;
            m_full = 1'b1;
        end
    endtask

    task automatic model_load(output logic [31:0] v);
        if (m_full) begin
            v = m_hold;
            m_full = 1'b0;
        end else begin
            v = 32'd0;
            m_und++;
        end
    endtask

    task automatic write_hold(input logic [31:0] v);
        bus.tx_data  = v;
        bus.tx_valid = 1'b1;
        model_write(v);
        tick(1);
        bus.tx_valid = 1'b0;
    endtask

    // One cs_n-low transfer of nw words. wr_mask[w] writes the holding register ahead of word w's load.
    // abort_bits>0 raises cs_n after that many bits of the final word. sim_wr writes in the same cycle as the first load.
    task automatic xfer(input logic pol, input logic pha, input logic [5:0] sz6, input int nw,
                        input logic [7:0] wr_mask, input int abort_bits, input bit sim_wr,
                        input bit fixed, input logic [31:0] fix_mo, input logic [31:0] fix_tx);
        int eff, nbits, und0, mund0;
        logic [31:0] mask, exp_tx, nxt, mo, got, txv;
        bit part;
        eff   = (sz6 > 6'd31) ? 31 : int'(sz6);
        mask  = (eff == 31) ? 32'hFFFF_FFFF : ((32'd1 << (eff + 1)) - 32'd1);
        und0  = und_cnt;
        mund0 = m_und;
        exp_rx.delete();
        rx_got.delete();
        cpol = pol; cpha = pha; sz = sz6; sck = pol; mosi = 1'b0;
        tick(4);
        txv = fixed ? fix_tx : $urandom;
        if (!sim_wr && wr_mask[0]) write_hold(txv);
        tick(2);
        cs_n = 1'b0;
        if (sim_wr) begin
            tick(2);
            bus.tx_data  = txv;
            bus.tx_valid = 1'b1;
            model_load(exp_tx);
            model_write(txv);
            tick(1);
            bus.tx_valid = 1'b0;
            tick(3);
        end else begin
            model_load(exp_tx);
            tick(6);
        end
`ifdef SPITGT_MISO_OE_EN
        check_eq("miso_oe_active", 32'(miso_oe), 32'd1);
`endif
        for (int w = 0; w < nw; w++) begin
            mo    = (fixed ? fix_mo : $urandom) & mask;
            part  = (abort_bits > 0) && (w == nw - 1);
            nbits = part ? abort_bits : eff + 1;
            got   = 32'd0;
            nxt   = 32'd0;
            for (int b = 0; b < nbits; b++) begin
                if (b == 1 && w + 1 < nw && wr_mask[w+1]) write_hold(fixed ? fix_tx : $urandom);
                if (!pha) begin
                    mosi = mo[eff-b];
                    tick(H);
                    sck = !pol;
                    got = {got[30:0], miso};
                    last_samp = cyc;
                    tick(H);
                    sck = pol;
                    if (b == eff) model_load(nxt);
                end else begin
                    sck  = !pol;
                    mosi = mo[eff-b];
                    tick(H);
                    sck = pol;
                    got = {got[30:0], miso};
                    last_samp = cyc;
                    if (b == eff) model_load(nxt);
                    tick(H);
                end
            end
            if (!part) begin
                check_eq("miso_word", got, exp_tx & mask);
                exp_rx.push_back(mo);
            end
            exp_tx = nxt;
        end
        tick(4);
        cs_n = 1'b1;
        tick(2);
        check_eq("busy_hold", 32'(busy), 32'd1);
        tick(1);
        check_eq("busy_fall", 32'(busy), 32'd0);
        check_eq("miso_idle", 32'(miso), 32'd0);
`ifdef SPITGT_MISO_OE_EN
        check_eq("miso_oe_idle", 32'(miso_oe), 32'd0);
`endif
        tick(6);
        check_eq("rx_count", 32'(rx_got.size()), 32'(exp_rx.size()));
        while (exp_rx.size() > 0 && rx_got.size() > 0)
            check_eq("rx_word", rx_got.pop_front(), exp_rx.pop_front());
        check_eq("underruns", 32'(und_cnt - und0), 32'(m_und - mund0));
        check_eq("tx_ready", 32'(bus.tx_ready), 32'(!m_full));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
        check_eq({pfx, "_busy"},     32'(busy),         32'd0);
        check_eq({pfx, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
        check_eq({pfx, "_underrun"}, 32'(underrun),     32'd0);
        check_eq({pfx, "_rx_data"},  bus.rx_data,       32'd0);
        check_eq({pfx, "_miso"},     32'(miso),         32'd0);
`ifdef SPITGT_MISO_OE_EN
        check_eq({pfx, "_miso_oe"},  32'(miso_oe),      32'd0);
`endif
    endtask

    initial begin
        logic [31:0] dummy;
        bus.tx_data  = 32'd0;
        bus.tx_valid = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick(4);

        // Mode 0 receive of 0xA5.
        xfer(1'b0, 1'b0, 6'd7, 1, 8'h00, 0, 1'b0, 1'b1, 32'h0000_00A5, 32'd0);
        // Mode 3 transmit of 0x1234.
        xfer(1'b1, 1'b1, 6'd15, 1, 8'h01, 0, 1'b0, 1'b1, 32'h0000_5A3C, 32'h0000_1234);
        // Mode 1 back-to-back, holding written only for word 1.
        xfer(1'b0, 1'b1, 6'd31, 2, 8'h01, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        // Abort after 5 of 8 bits, then a clean transfer.
        xfer(1'b0, 1'b0, 6'd7, 1, 8'h01, 5, 1'b0, 1'b0, 32'd0, 32'd0);
        xfer(1'b0, 1'b0, 6'd7, 1, 8'h01, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        // Write landing in the same cycle as a load from empty: word 1 zero, word 2 the write.
        xfer(1'b0, 1'b0, 6'd7, 2, 8'h00, 0, 1'b1, 1'b1, 32'h0000_003C, 32'h0000_00C9);

        for (int i = 0; i < 6; i++) begin
            logic [5:0] s;
            s = (i == 0) ? 6'd45 : 6'($urandom_range(3, 31));
            xfer(1'($urandom), 1'($urandom), s, int'($urandom_range(1, 3)), 8'($urandom),
                 0, 1'b0, 1'b0, 32'd0, 32'd0);
        end

        // Reset in the middle of a transfer with the holding register full.
        cpol = 1'b0; cpha = 1'b0; sz = 6'd7; sck = 1'b0;
        tick(4);
        write_hold(32'h0000_0081);
        cs_n = 1'b0;
        model_load(dummy);
        tick(4);
        write_hold(32'h0000_0042);
        sck = 1'b1;
        tick(H);
        sck = 1'b0;
        tick(3);
        resetn = 1'b0;
        tick(1);
        check_reset_outputs("midreset");
        cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        m_full = 1'b0;
        tick(4);
        resetn = 1'b1;
        tick(4);
        xfer(1'b1, 1'b0, 6'd11, 2, 8'h03, 0, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
